// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared CPU defines for the fetch queue (reset PC, bus size code, FSM states, entry layout).
package ifetch_queue_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HALT = 2'd2} fetchStateT;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic adel;
  } ifqEntryT;
  localparam int ENTRY_W = $bits(ifqEntryT);
endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: circular entry store with flush and occupancy count.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [ENTRY_W-1:0] wrEntry,
  output logic [ENTRY_W-1:0] headEntry,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  assign headEntry = mem[rdPtr];
  always_ff @(posedge clk)
    if (push && !flush && !rst) mem[wrPtr] <= wrEntry;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      assert (!(push && !pop && count == (AW+1)'(DEPTH)));
      assert (!(pop && count == '0));
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue over an SRAM-like bus with credit flow control and redirect discard.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
  input  logic clk,
  input  logic rst,
  output logic inst_req,
  output logic [31:0] inst_addr,
  output logic inst_wr,
  output logic [1:0] inst_size,
  output logic [31:0] inst_wdata,
  input  logic inst_addr_ok,
  input  logic inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic out_ready,
  output logic out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic out_adel
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetchStateT state;
  logic [31:0] fetchPc, respPc;
  logic [CW-1:0] inflight, discard, count, credit;
  logic misaligned, accept, keep, adelPush, bypass, push, pop, headValid;
  ifqEntryT head, wrEntry, outEntry;
  assign credit = CW'(DEPTH) - count - inflight;
  assign misaligned = fetchPc[1:0] != 2'b00;
  assign inst_req = ~rst & (state == REQ) & ~misaligned & (credit != '0);
  assign inst_addr = rst ? RESET_PC : fetchPc;
  assign inst_wr = 1'b0;
  assign inst_size = SIZE_WORD;
  assign inst_wdata = '0;
  assign accept = inst_req & inst_addr_ok;
  assign keep = ~rst & inst_data_ok & (discard == '0) & ~redirect_valid;
  // A misaligned PC never reaches the bus; it becomes one faulting entry.
  assign adelPush = ~rst & (state == REQ) & misaligned & (credit != '0) & ~redirect_valid;
  assign headValid = count != '0;
`ifdef IFQ_BYPASS_EN
  assign bypass = keep & ~headValid;
`else
  assign bypass = 1'b0;
`endif
  assign wrEntry = adelPush ? ifqEntryT'{pc: fetchPc, instr: 32'h0, adel: 1'b1}
                            : ifqEntryT'{pc: respPc, instr: inst_rdata, adel: 1'b0};
  assign outEntry = bypass ? ifqEntryT'{pc: respPc, instr: inst_rdata, adel: 1'b0} : head;
  assign out_valid = ~rst & (headValid | bypass);
  assign out_pc = out_valid ? outEntry.pc : '0;
  assign out_instr = out_valid ? outEntry.instr : '0;
  assign out_adel = out_valid & outEntry.adel;
  assign pop = out_valid & out_ready & headValid & ~redirect_valid;
  assign push = (keep & ~(bypass & out_ready)) | adelPush;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .wrEntry(wrEntry),
    .headEntry(head),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      fetchPc <= RESET_PC;
      respPc <= RESET_PC;
      inflight <= '0;
      discard <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(inst_data_ok);
      if (redirect_valid) begin
        discard <= inflight + CW'(accept) - CW'(inst_data_ok);
        fetchPc <= redirect_pc;
        respPc <= redirect_pc;
        state <= REQ;
      end else begin
        if (inst_data_ok && discard != '0) discard <= discard - CW'(1);
        if (keep) respPc <= respPc + 32'd4;
        if (accept) fetchPc <= fetchPc + 32'd4;
        if (state == IDLE && credit != '0) state <= REQ;
        else if (state == REQ && adelPush) state <= HALT;
        else if (state == REQ && (credit == '0 || (accept && credit == CW'(1)))) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed plus randomized bench for ifetch_queue, scored by an epoch-tagged bus and stream model.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'hBFC00000;
  localparam logic [31:0] KEY = 32'h9BC80001;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic inst_req, inst_wr, out_valid, out_adel;
  logic [31:0] inst_addr, inst_wdata, out_pc, out_instr;
  logic [1:0] inst_size;
  logic inst_addr_ok = 1'b0, inst_data_ok = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst_rdata = '0, redirect_pc = '0;
  int checks = 0, errors = 0;
  logic [31:0] pendAddr[$];
  int pendEpoch[$];
  int epoch = 0, keptE = 0, poppedE = 0;
  logic [31:0] fetchExp = RPC, expPc = RPC;
  bit adelExp = 1'b0, adelSeen = 1'b0;
  logic sReq, sOv, sAdel;
  logic [31:0] sAddr, sPc, sIns;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic setIn(input bit aok, input bit dok, input bit rdy);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    out_ready = rdy;
    redirect_valid = 1'b0;
  endtask

  // One bus cycle: respond from the outstanding list, sample, score, then advance the model at the edge.
  task automatic cyc();
    bit kept;
    if (pendAddr.size() == 0) inst_data_ok = 1'b0;
    inst_rdata = inst_data_ok ? pendAddr[0] ^ KEY : 32'h0;
    #1;
    sReq = inst_req; sAddr = inst_addr; sOv = out_valid; sPc = out_pc; sIns = out_instr; sAdel = out_adel;
    if (rst) begin
      check("rst_req", sReq, 0);
      check("rst_addr", sAddr, RPC);
      check("rst_ov", sOv, 0);
      check("rst_pc", sPc, 0);
      check("rst_size", inst_size, 2);
    end else begin
      check("inflight_cap", pendAddr.size() <= DEPTH, 1);
      if (sReq) check("req_addr", sAddr, fetchExp);
      if (fetchExp[1:0] != 2'b00) check("adel_noreq", sReq, 0);
      if (adelSeen) check("halt_ov", sOv, 0);
      if (sOv && out_ready && !redirect_valid) begin
        check("pop_pc", sPc, expPc);
        check("pop_adel", sAdel, adelExp);
        check("pop_instr", sIns, adelExp ? 32'h0 : expPc ^ KEY);
        if (adelExp) adelSeen = 1'b1;
        else begin
          expPc += 4;
          poppedE++;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      pendAddr.delete(); pendEpoch.delete();
      epoch++; fetchExp = RPC; expPc = RPC; adelExp = 1'b0; adelSeen = 1'b0; keptE = 0; poppedE = 0;
    end else begin
      if (sReq && inst_addr_ok) begin
        pendAddr.push_back(sAddr);
        pendEpoch.push_back(epoch);
      end
      if (inst_data_ok) begin
        kept = pendEpoch[0] == epoch && !redirect_valid;
        void'(pendAddr.pop_front());
        void'(pendEpoch.pop_front());
        if (kept) keptE++;
      end
      if (redirect_valid) begin
        epoch++; fetchExp = redirect_pc; expPc = redirect_pc;
        adelExp = redirect_pc[1:0] != 2'b00; adelSeen = 1'b0; keptE = 0; poppedE = 0;
      end else if (sReq && inst_addr_ok) fetchExp += 4;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    setIn(0, 0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc, input bit aok, input bit dok, input bit rdy);
    setIn(aok, dok, rdy);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc();
  endtask

  initial begin
    int acc;
    bit got;
    @(negedge clk);
    doReset();
    check("tie_wr", {31'd0, inst_wr} | inst_wdata, 0);
    // streaming: one instruction per cycle
    for (int c = 0; c < 8; c++) begin
      setIn(1, 1, 1);
      cyc();
      if (c >= 2 - int'(BYP) && c < 5 - int'(BYP)) begin
        check("seq_ov", sOv, 1);
        check("seq_pc", sPc, RPC + 32'(4 * (c - 2 + int'(BYP))));
      end
    end
    // credit limit with decode stalled
    doReset();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      setIn(1, 1, 0);
      cyc();
      acc += int'(sReq && inst_addr_ok);
    end
    check("full_accepts", acc, 4);
    check("full_noreq", sReq, 0);
    setIn(0, 0, 1);
    cyc();
    check("full_pop_ov", sOv, 1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      setIn(1, 1, 0);
      cyc();
      acc += int'(sReq && inst_addr_ok);
    end
    check("refill_accepts", acc, 1);
    // redirect with two requests in flight
    doReset();
    setIn(1, 0, 0); cyc();
    setIn(1, 0, 0); cyc();
    check("two_inflight", pendAddr.size(), 2);
    redirect(32'h80001000, 0, 0, 0);
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      setIn(1, 1, 1);
      cyc();
      if (c < 2) check("drop_ov", sOv, 0);
      if (sOv && !got) begin
        check("redir_pc", sPc, 32'h80001000);
        got = 1'b1;
      end
    end
    check("redir_seen", got, 1);
    // misaligned redirect then halt
    redirect(32'h80001002, 1, 1, 0);
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      setIn(1, 1, 0);
      cyc();
      acc += int'(sReq);
    end
    check("mis_req", acc, 0);
    check("mis_ov", sOv, 1);
    check("mis_adel", sAdel, 1);
    check("mis_pc", sPc, 32'h80001002);
    setIn(1, 1, 1); cyc();
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      setIn(1, 1, 1);
      cyc();
      acc += int'(sReq) + int'(sOv);
    end
    check("halt_quiet", acc, 0);
    // redirect, pop and response in the same cycle
    doReset();
    setIn(1, 0, 0); cyc();
    setIn(1, 1, 0); cyc();
    redirect(32'h80002000, 0, 1, 1);
    check("coll_ov_before", sOv, 1);
    setIn(0, 0, 0); cyc();
    check("coll_empty", sOv, 0);
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      setIn(1, 1, 1);
      cyc();
      if (sOv && !got) begin
        check("coll_pc", sPc, 32'h80002000);
        got = 1'b1;
      end
    end
    check("coll_seen", got, 1);
    // response-to-output latency
    doReset();
    setIn(1, 0, 0); cyc();
    setIn(0, 1, 0); cyc();
    check("byp_ov", sOv, BYP);
    check("byp_instr", sOv ? sIns : 32'h0, BYP ? 32'h24080001 : 32'h0);
    setIn(0, 0, 0); cyc();
    check("lat_ov", sOv, 1);
    check("lat_instr", sIns, 32'h24080001);
    // randomized traffic with occasional redirects and one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      setIn($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom() & ~32'h3) | ($urandom_range(0, 4) == 0 ? 32'h2 : 32'h0);
      end
      rst = (c == 1500);
      cyc();
    end
    rst = 1'b0;
    // drain: every kept response must come out exactly once
    redirect(32'h80003000, 0, 1, 1);
    for (int c = 0; c < 40; c++) begin
      setIn(c < 10, 1, 1);
      cyc();
    end
    check("drain_pend", pendAddr.size(), 0);
    check("drain_ov", sOv, 0);
    check("drain_count", poppedE, keptE);
    check("drain_some", keptE > 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
